// File: rtl/mlp_seq_datapath.sv
// Self-sequencing MLP datapath: N_NEU serial-MAC lanes, weights streamed from an
// external 1-cycle-latency memory, N_LAYER layers sequenced internally, arg-max output.
module mlp_seq_datapath #(
    parameter int DW      = 8,
    parameter int N_IN    = 62,
    parameter int N_NEU   = 10,
    parameter int N_LAYER = 3,
    parameter int FRAC    = 4,
    parameter int ACC_W   = 2*DW + $clog2(N_IN) + 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic [N_IN*DW-1:0]                               in_data,
    output logic                                             w_rd,
    output logic [$clog2(N_LAYER)-1:0]                       w_layer,
    output logic [$clog2((N_IN > N_NEU) ? N_IN : N_NEU)-1:0] w_idx,
    input  logic [N_NEU*DW-1:0]                              w_data,
    input  logic [N_NEU*DW-1:0]                              bias_in,
    output logic                                             busy,
    output logic                                             ready,
    output logic [7:0]                                       class_out,
    output logic [N_NEU*DW-1:0]                              score_out
);
    localparam int LW = $clog2(N_LAYER);
    localparam int IW = $clog2((N_IN > N_NEU) ? N_IN : N_NEU);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, ACT, ARG, DONE} state_e;

    state_e                  state_q, state_d;
    logic [LW-1:0]           layer_q, layer_d;
    logic [IW-1:0]           k_q, k_d;
    logic [IW-1:0]           kd_q, kd_d;
    logic                    rd_q, rd_d;
    logic signed [DW-1:0]    samp_q [N_IN];
    logic signed [DW-1:0]    samp_d [N_IN];
    logic signed [DW-1:0]    act_q [N_NEU];
    logic signed [DW-1:0]    act_d [N_NEU];
    logic signed [DW-1:0]    score_q [N_NEU];
    logic signed [DW-1:0]    score_d [N_NEU];
    logic signed [ACC_W-1:0] acc_q [N_NEU];
    logic signed [ACC_W-1:0] acc_d [N_NEU];
    logic [7:0]              class_q, class_d;

    logic signed [DW-1:0]    x_cur;
    logic signed [2*DW-1:0]  prod [N_NEU];
    logic signed [ACC_W:0]   sum_w [N_NEU];
    logic signed [DW-1:0]    y_w [N_NEU];
    logic [7:0]              best_idx;
    logic signed [DW-1:0]    best_val;
    logic [IW-1:0]           last_k;
    logic                    last_layer;

    assign last_layer = (layer_q == LW'(N_LAYER-1));
    assign last_k     = (layer_q == '0) ? IW'(N_IN-1) : IW'(N_NEU-1);

    // Operand for the weight returned this cycle: element index delayed with the read.
    always_comb begin
        x_cur = '0;
        if (layer_q == '0) begin
            for (int unsigned i = 0; i < N_IN; i++)
                if (kd_q == IW'(i)) x_cur = samp_q[i];
        end else begin
            for (int unsigned i = 0; i < N_NEU; i++)
                if (kd_q == IW'(i)) x_cur = act_q[i];
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < N_NEU; j++) begin
            prod[j]  = $signed(w_data[j*DW +: DW]) * x_cur;
            sum_w[j] = ($signed({acc_q[j][ACC_W-1], acc_q[j]}) >>> FRAC)
                     + $signed({{(ACC_W+1-DW){bias_in[j*DW+DW-1]}}, bias_in[j*DW +: DW]});
            if (sum_w[j] > SAT_MAX)      y_w[j] = {1'b0, {(DW-1){1'b1}}};
            else if (sum_w[j] < SAT_MIN) y_w[j] = {1'b1, {(DW-1){1'b0}}};
            else                         y_w[j] = sum_w[j][DW-1:0];
            if (!last_layer && y_w[j][DW-1]) y_w[j] = '0;
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = act_q[0];
        for (int unsigned j = 1; j < N_NEU; j++) begin
            if (act_q[j] > best_val) begin
                best_val = act_q[j];
                best_idx = 8'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        k_d     = k_q;
        kd_d    = k_q;
        rd_d    = (state_q == RUN);
        samp_d  = samp_q;
        act_d   = act_q;
        score_d = score_q;
        acc_d   = acc_q;
        class_d = class_q;

        if (rd_q) begin
            for (int unsigned j = 0; j < N_NEU; j++)
                acc_d[j] = acc_q[j] + {{(ACC_W-2*DW){prod[j][2*DW-1]}}, prod[j]};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    layer_d = '0;
                    k_d     = '0;
                    for (int unsigned i = 0; i < N_IN; i++) samp_d[i] = in_data[i*DW +: DW];
                    for (int unsigned j = 0; j < N_NEU; j++) acc_d[j] = '0;
                end
            end
            RUN: begin
                k_d = k_q + IW'(1);
                if (k_q == last_k) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end
            end
            DRAIN: state_d = ACT;
            ACT: begin
                for (int unsigned j = 0; j < N_NEU; j++) begin
                    act_d[j] = y_w[j];
                    acc_d[j] = '0;
                end
                if (last_layer) begin
                    state_d = ARG;
                end else begin
                    state_d = RUN;
                    layer_d = layer_q + LW'(1);
                    k_d     = '0;
                end
            end
            ARG: begin
                class_d = best_idx;
                score_d = act_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            layer_q <= '0;
            k_q     <= '0;
            kd_q    <= '0;
            rd_q    <= 1'b0;
            class_q <= '0;
            for (int unsigned i = 0; i < N_IN; i++) samp_q[i] <= '0;
            for (int unsigned j = 0; j < N_NEU; j++) begin
                act_q[j]   <= '0;
                score_q[j] <= '0;
                acc_q[j]   <= '0;
            end
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            k_q     <= k_d;
            kd_q    <= kd_d;
            rd_q    <= rd_d;
            class_q <= class_d;
            samp_q  <= samp_d;
            act_q   <= act_d;
            score_q <= score_d;
            acc_q   <= acc_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ready     = (state_q == DONE);
    assign w_rd      = (state_q == RUN);
    assign w_layer   = layer_q;
    assign w_idx     = k_q;
    assign class_out = class_q;

    always_comb begin
        score_out = '0;
        for (int unsigned j = 0; j < N_NEU; j++) score_out[j*DW +: DW] = score_q[j];
    end
endmodule

// File: tb/tb_mlp_seq_datapath.sv
// Directed bench for mlp_seq_datapath: default 62/10/3 instance plus a 4/3/2 FRAC=0 instance,
// each fed by a 1-cycle-latency weight memory model and a combinational bias table.
module tb_mlp_seq_datapath;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [495:0] in_data = '0;
    logic         w_rd;
    logic [1:0]   w_layer;
    logic [5:0]   w_idx;
    logic [79:0]  w_data = '0;
    logic [79:0]  bias_in;
    logic         busy, ready;
    logic [7:0]   class_out;
    logic [79:0]  score_out;

    logic         s_start = 1'b0;
    logic [31:0]  s_in = '0;
    logic         s_w_rd;
    logic [0:0]   s_w_layer;
    logic [1:0]   s_w_idx;
    logic [23:0]  s_w_data = '0;
    logic [23:0]  s_bias;
    logic         s_busy, s_ready;
    logic [7:0]   s_class;
    logic [23:0]  s_score;

    mlp_seq_datapath dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .w_rd(w_rd), .w_layer(w_layer), .w_idx(w_idx), .w_data(w_data), .bias_in(bias_in),
        .busy(busy), .ready(ready), .class_out(class_out), .score_out(score_out)
    );

    mlp_seq_datapath #(.DW(8), .N_IN(4), .N_NEU(3), .N_LAYER(2), .FRAC(0)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_data(s_in),
        .w_rd(s_w_rd), .w_layer(s_w_layer), .w_idx(s_w_idx), .w_data(s_w_data), .bias_in(s_bias),
        .busy(s_busy), .ready(s_ready), .class_out(s_class), .score_out(s_score)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [79:0] wmem(input int md, input int l, input int k);
        logic [79:0] r;
        r = '0;
        if (md == 2) begin
            if (l == 0) begin
                r[0*8 +: 8] = 8'h01;
                r[2*8 +: 8] = 8'hFF;
            end else if (l == 1) begin
                if (k == 0) r[1*8 +: 8] = 8'h01;
                if (k == 2) r[7*8 +: 8] = 8'hF0;
            end else begin
                if (k == 1) begin
                    r[4*8 +: 8] = 8'h10;
                    r[5*8 +: 8] = 8'hF0;
                    r[6*8 +: 8] = 8'hFF;
                end
                if (k == 7) r[8*8 +: 8] = 8'h10;
            end
        end
        return r;
    endfunction

    function automatic logic [79:0] bmem(input int md, input int l);
        logic [79:0] r;
        r = '0;
        if (l == 2) begin
            if (md == 0) r[3*8 +: 8] = 8'h05;
            if (md == 1) for (int j = 0; j < 10; j++) r[j*8 +: 8] = 8'hF9;
            if (md == 2) begin
                r[0*8 +: 8] = 8'hFD;
                r[4*8 +: 8] = 8'h02;
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] smem(input int l, input int k);
        logic [23:0] r;
        if (l == 0) r = 24'h01FF7F;
        else        r = (k == 2) ? 24'h0100FF : 24'h0000FF;
        return r;
    endfunction

    always @(posedge clk) begin
        if (w_rd)   w_data   <= wmem(mode, int'(w_layer), int'(w_idx));
        if (s_w_rd) s_w_data <= smem(int'(s_w_layer), int'(s_w_idx));
    end

    always @* begin
        bias_in = bmem(mode, int'(w_layer));
        s_bias  = (s_w_layer == 1'b1) ? 24'h00FB00 : 24'h000000;
    end

    int rd_lay[$];
    int rd_idx[$];
    int rd_cyc[$];
    int ready_cnt = 0, ready_cyc = 0, acc_cyc = 0, idle_len = 0, last_gap = 0;
    int s_ready_cnt = 0, s_ready_cyc = 0, s_acc_cyc = 0;
    bit busy_p = 1'b0, s_busy_p = 1'b0;

    always @(negedge clk) begin
        if (busy && !busy_p) begin
            acc_cyc  = cyc;
            last_gap = idle_len;
        end
        idle_len = busy ? 0 : idle_len + 1;
        busy_p   = busy;
        if (w_rd) begin
            rd_lay.push_back(int'(w_layer));
            rd_idx.push_back(int'(w_idx));
            rd_cyc.push_back(cyc);
        end
        if (ready) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (s_busy && !s_busy_p) s_acc_cyc = cyc;
        s_busy_p = s_busy;
        if (s_ready) begin
            s_ready_cnt++;
            s_ready_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input bit sm, input int target, input string tag);
        int n;
        n = 0;
        while (((sm ? s_ready_cnt : ready_cnt) < target) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, " ready seen"}, 80'((sm ? s_ready_cnt : ready_cnt) >= target), 80'(1));
    endtask

    task automatic clear_reads();
        rd_lay.delete();
        rd_idx.delete();
        rd_cyc.delete();
    endtask

    // Expected order (0,0..61),(1,0..9),(2,0..9); each group starts len+2 cycles after the previous.
    task automatic check_reads(input string tag);
        int n, off, len;
        logic [79:0] o, e;
        chk({tag, " read count"}, 80'(rd_lay.size()), 80'(82));
        n = 0;
        off = 0;
        for (int l = 0; l < 3; l++) begin
            len = (l == 0) ? 62 : 10;
            for (int i = 0; i < len; i++) begin
                if (n < rd_lay.size())
                    o = {32'(rd_lay[n]), 16'(rd_idx[n]), 32'(rd_cyc[n] - acc_cyc)};
                else
                    o = '1;
                e = {32'(l), 16'(i), 32'(off + i)};
                chk($sformatf("%s read %0d", tag, n), o, e);
                n++;
            end
            off = off + len + 2;
        end
    endtask

    logic [79:0] exp_score;
    int r1;

    initial begin
        repeat (3) tick();
        chk("rst busy", 80'(busy), 80'(0));
        chk("rst ready", 80'(ready), 80'(0));
        chk("rst w_rd", 80'(w_rd), 80'(0));
        chk("rst w_layer", 80'(w_layer), 80'(0));
        chk("rst w_idx", 80'(w_idx), 80'(0));
        chk("rst class", 80'(class_out), 80'(0));
        chk("rst score", score_out, 80'(0));
        chk("rst small busy", 80'(s_busy), 80'(0));
        chk("rst small score", 80'(s_score), 80'(0));
        rst = 1'b1;
        tick();

        // Zero weights, output bias lane 3 = 5.
        mode = 0;
        for (int i = 0; i < 62; i++) in_data[i*8 +: 8] = 8'($urandom);
        clear_reads();
        ready_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(1'b0, 1, "zero-w");
        repeat (4) tick();
        chk("zero-w class", 80'(class_out), 80'(3));
        chk("zero-w score", score_out, 80'h05 << 24);
        chk("zero-w ready count", 80'(ready_cnt), 80'(1));
        chk("zero-w latency", 80'(ready_cyc - acc_cyc), 80'(89));
        check_reads("zero-w");

        // Reset at E30 and E31 of a run.
        mode = 1;
        ready_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        chk("pre-reset w_idx", 80'(w_idx), 80'(29));
        rst = 1'b0;
        tick();
        chk("mid-rst busy", 80'(busy), 80'(0));
        chk("mid-rst ready", 80'(ready), 80'(0));
        chk("mid-rst w_rd", 80'(w_rd), 80'(0));
        chk("mid-rst w_layer", 80'(w_layer), 80'(0));
        chk("mid-rst w_idx", 80'(w_idx), 80'(0));
        chk("mid-rst class", 80'(class_out), 80'(0));
        chk("mid-rst score", score_out, 80'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("post-rst idle", 80'(busy), 80'(0));
        chk("post-rst no ready", 80'(ready_cnt), 80'(0));

        // Fresh run: every output score is bias -7, no ReLU on the last layer, tie -> lane 0.
        clear_reads();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(1'b0, 1, "tie");
        repeat (4) tick();
        for (int j = 0; j < 10; j++) exp_score[j*8 +: 8] = 8'hF9;
        chk("tie class", 80'(class_out), 80'(0));
        chk("tie score", score_out, exp_score);
        chk("tie ready count", 80'(ready_cnt), 80'(1));
        chk("tie latency", 80'(ready_cyc - acc_cyc), 80'(89));

        // MAC/shift/ReLU network with start held high across two runs.
        mode = 2;
        for (int i = 0; i < 62; i++) in_data[i*8 +: 8] = 8'h10;
        exp_score = '0;
        exp_score[0*8 +: 8] = 8'hFD;
        exp_score[4*8 +: 8] = 8'h05;
        exp_score[5*8 +: 8] = 8'hFD;
        exp_score[6*8 +: 8] = 8'hFF;
        clear_reads();
        ready_cnt = 0;
        start = 1'b1;
        wait_ready(1'b0, 1, "held run1");
        chk("held run1 class", 80'(class_out), 80'(4));
        chk("held run1 score", score_out, exp_score);
        chk("held run1 latency", 80'(ready_cyc - acc_cyc), 80'(89));
        check_reads("held run1");
        r1 = ready_cyc;
        clear_reads();
        wait_ready(1'b0, 2, "held run2");
        start = 1'b0;
        chk("held re-accept", 80'(acc_cyc - r1), 80'(2));
        chk("held idle gap", 80'(last_gap), 80'(1));
        chk("held run2 latency", 80'(ready_cyc - acc_cyc), 80'(89));
        chk("held run2 class", 80'(class_out), 80'(4));
        chk("held run2 score", score_out, exp_score);
        check_reads("held run2");
        repeat (4) tick();
        chk("held stop", 80'(busy), 80'(0));
        chk("held ready count", 80'(ready_cnt), 80'(2));

        // Small instance: hidden = 127, 0 (ReLU of -128), 127 (saturated from 508).
        s_in = 32'h7F7F7F7F;
        s_ready_cnt = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_ready(1'b1, 1, "small");
        repeat (3) tick();
        chk("small class", 80'(s_class), 80'(2));
        chk("small score", 80'(s_score), 80'(24'h7FFB80));
        chk("small latency", 80'(s_ready_cyc - s_acc_cyc), 80'(12));
        chk("small ready count", 80'(s_ready_cnt), 80'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
